// File: rtl/ecc_consts.sv
// secp256k1 curve constants, point-state widths and the scalar-multiply FSM encoding
// shared by the ECDSA datapath blocks.
package ecc_consts;

  localparam int COORD_W = 256;

  localparam logic [COORD_W-1:0] P_CONST =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [COORD_W-1:0] N_CONST =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam logic [COORD_W-1:0] GX =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [COORD_W-1:0] GY =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

  // Affine point with explicit point-at-infinity flag (x/y are don't-care when inf=1).
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               inf;
  } point_t;

  localparam int POINT_W = 2 * COORD_W + 1;

  localparam point_t PT_INF  = '{x: '0, y: '0, inf: 1'b1};
  localparam point_t PT_ZERO = '{x: '0, y: '0, inf: 1'b0};

  localparam logic [2:0] SM_IDLE     = 3'd0;
  localparam logic [2:0] SM_CHECK    = 3'd1;
  localparam logic [2:0] SM_DBL_REQ  = 3'd2;
  localparam logic [2:0] SM_DBL_WAIT = 3'd3;
  localparam logic [2:0] SM_ADD_REQ  = 3'd4;
  localparam logic [2:0] SM_ADD_WAIT = 3'd5;
  localparam logic [2:0] SM_NEXT     = 3'd6;
  localparam logic [2:0] SM_FINISH   = 3'd7;

endpackage

// File: rtl/scalar_mult_ctrl.sv
// MSB-first double-and-add sequencer for R = k*P driving an external point_add.
// Define SCALAR_MULT_CT_EN for constant-time mode: an addition is issued for every bit.
module scalar_mult_ctrl
  import ecc_consts::*;
#(
  parameter int KW = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [KW-1:0]      k,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic               pinf,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] rx,
  output logic [COORD_W-1:0] ry,
  output logic               rinf,
  output logic               pa_start,
  output logic [COORD_W-1:0] pa_x1,
  output logic [COORD_W-1:0] pa_y1,
  output logic               pa_inf1,
  output logic [COORD_W-1:0] pa_x2,
  output logic [COORD_W-1:0] pa_y2,
  output logic               pa_inf2,
  input  logic               pa_done,
  input  logic [COORD_W-1:0] pa_x3,
  input  logic [COORD_W-1:0] pa_y3,
  input  logic               pa_inf3
);

  localparam int IW = (KW > 1) ? $clog2(KW) : 1;

`ifdef SCALAR_MULT_CT_EN
  localparam bit CT_EN = 1'b1;
`else
  localparam bit CT_EN = 1'b0;
`endif

  logic [2:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [IW-1:0] idx_q, idx_d;
  point_t        p_q, p_d;
  point_t        acc_q, acc_d;
  point_t        res_q, res_d;
  point_t        op1_q, op1_d;
  point_t        op2_q, op2_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pa_start_q, pa_start_d;
  logic          bit_set;
  point_t        pa_res;

  assign bit_set = k_q[idx_q];
  assign pa_res  = '{x: pa_x3, y: pa_y3, inf: pa_inf3};

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    idx_d      = idx_q;
    p_d        = p_q;
    acc_d      = acc_q;
    res_d      = res_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    done_d     = 1'b0;
    pa_start_d = 1'b0;

    case (state_q)
      SM_IDLE: begin
        if (start) begin
          k_d     = k;
          p_d     = '{x: px, y: py, inf: pinf};
          acc_d   = PT_INF;
          idx_d   = IW'(KW - 1);
          state_d = SM_CHECK;
        end
      end
      SM_CHECK: begin
        if (p_q.inf || (!CT_EN && (k_q == '0))) state_d = SM_FINISH;
        else                                    state_d = SM_DBL_REQ;
      end
      SM_DBL_REQ: state_d = SM_DBL_WAIT;
      SM_DBL_WAIT: begin
        if (pa_done) begin
          acc_d   = pa_res;
          state_d = (CT_EN || bit_set) ? SM_ADD_REQ : SM_NEXT;
        end
      end
      SM_ADD_REQ: state_d = SM_ADD_WAIT;
      SM_ADD_WAIT: begin
        // In constant-time mode the sum is computed for clear bits too, but thrown away.
        if (pa_done) begin
          if (bit_set) acc_d = pa_res;
          state_d = SM_NEXT;
        end
      end
      SM_NEXT: begin
        if (idx_q == '0) begin
          state_d = SM_FINISH;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = SM_DBL_REQ;
        end
      end
      SM_FINISH: begin
        res_d   = acc_q;
        done_d  = 1'b1;
        state_d = SM_IDLE;
      end
      default: state_d = SM_IDLE;
    endcase

    // Operands are loaded on entry to a request state and then held until the next request.
    if (state_d == SM_DBL_REQ) begin
      op1_d      = acc_d;
      op2_d      = acc_d;
      pa_start_d = 1'b1;
    end else if (state_d == SM_ADD_REQ) begin
      op1_d      = acc_d;
      op2_d      = p_q;
      pa_start_d = 1'b1;
    end
  end

  assign busy_d = (state_d != SM_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SM_IDLE;
      k_q        <= '0;
      idx_q      <= '0;
      p_q        <= PT_ZERO;
      acc_q      <= PT_INF;
      res_q      <= PT_INF;
      op1_q      <= PT_ZERO;
      op2_q      <= PT_ZERO;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pa_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
      p_q        <= p_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pa_start_q <= pa_start_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx       = res_q.x;
  assign ry       = res_q.y;
  assign rinf     = res_q.inf;
  assign pa_start = pa_start_q;
  assign pa_x1    = op1_q.x;
  assign pa_y1    = op1_q.y;
  assign pa_inf1  = op1_q.inf;
  assign pa_x2    = op2_q.x;
  assign pa_y2    = op2_q.y;
  assign pa_inf2  = op2_q.inf;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl: behavioural secp256k1 point_add with random latency,
// independent right-to-left reference multiplier, known multiples of G.
module tb_scalar_mult_ctrl;

  localparam int KW     = 256;
  localparam int BUDGET = 30000;

  localparam logic [255:0] FP  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] FN  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
  localparam logic [255:0] GXC = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] GYC = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
  localparam logic [255:0] G2X = 256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
  localparam logic [255:0] G2Y = 256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;
  localparam logic [255:0] G3X = 256'hF9308A01_9258C310_49344F85_F89D5229_B531C845_836F99B0_8601F113_BCE036F9;
  localparam logic [255:0] G3Y = 256'h388F7B0F_632DE814_0FE337E6_2A37F356_6500A999_34C2231B_6CB9FD75_84B8E672;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [KW-1:0] k = '0;
  logic [255:0] px = '0;
  logic [255:0] py = '0;
  logic         pinf = 1'b0;
  logic         busy, done, rinf, pa_start, pa_inf1, pa_inf2;
  logic [255:0] rx, ry, pa_x1, pa_y1, pa_x2, pa_y2;
  logic         pa_done;
  logic [255:0] pa_x3, pa_y3;
  logic         pa_inf3;

  int n_tests = 0;
  int n_fail = 0;
  int pa_cnt = 0;
  int stab_err = 0;
  int overlap_err = 0;
  int lat_max = 3;

  scalar_mult_ctrl #(.KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k), .px(px), .py(py), .pinf(pinf),
    .busy(busy), .done(done), .rx(rx), .ry(ry), .rinf(rinf),
    .pa_start(pa_start), .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_inf1(pa_inf1),
    .pa_x2(pa_x2), .pa_y2(pa_y2), .pa_inf2(pa_inf2),
    .pa_done(pa_done), .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_inf3(pa_inf3)
  );

  always #5 clk = ~clk;

  // Field arithmetic mod p
  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    t = t % {256'd0, FP};
    return t[255:0];
  endfunction

  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, FP}) s = s - {1'b0, FP};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    if (a >= b) return a - b;
    return a + (FP - b);
  endfunction

  function automatic logic [255:0] finv(input logic [255:0] a);
    logic [255:0] r, base, e;
    r = 256'd1; base = a; e = FP - 256'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = fmul(r, base);
      base = fmul(base, base);
    end
    return r;
  endfunction

  // Affine group law; result packed as {x, y, inf}
  function automatic logic [512:0] padd(input logic [255:0] x1, input logic [255:0] y1, input logic i1,
                                        input logic [255:0] x2, input logic [255:0] y2, input logic i2);
    logic [255:0] lam, x3, y3;
    if (i1) return {x2, y2, i2};
    if (i2) return {x1, y1, 1'b0};
    if (x1 == x2) begin
      if (fadd(y1, y2) == 256'd0) return {256'd0, 256'd0, 1'b1};
      lam = fmul(fmul(256'd3, fmul(x1, x1)), finv(fadd(y1, y1)));
    end else begin
      lam = fmul(fsub(y2, y1), finv(fsub(x2, x1)));
    end
    x3 = fsub(fsub(fmul(lam, lam), x1), x2);
    y3 = fsub(fmul(lam, fsub(x1, x3)), y1);
    return {x3, y3, 1'b0};
  endfunction

  // Reference k*P, LSB-first, independent of the sequencing under test
  function automatic logic [512:0] ref_mult(input logic [255:0] kk, input logic [255:0] x,
                                            input logic [255:0] y, input logic inf);
    logic [512:0] q, d;
    q = {256'd0, 256'd0, 1'b1};
    d = {x, y, inf};
    for (int i = 0; i < KW; i++) begin
      if (kk[i]) q = padd(q[512:257], q[256:1], q[0], d[512:257], d[256:1], d[0]);
      d = padd(d[512:257], d[256:1], d[0], d[512:257], d[256:1], d[0]);
    end
    return q;
  endfunction

  function automatic int exp_ops(input logic [255:0] kk, input logic ii);
    if (ii) return 0;
`ifdef SCALAR_MULT_CT_EN
    return 2 * KW;
`else
    if (kk == '0) return 0;
    return KW + $countones(kk);
`endif
  endfunction

  // Behavioural point_add: random done latency, watches handshake discipline
  logic         m_busy;
  int           m_left;
  logic [512:0] m_op1, m_op2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_left  <= 0;
      pa_done <= 1'b0;
    end else begin
      pa_done <= 1'b0;
      if (m_busy) begin
        if (pa_start) overlap_err <= overlap_err + 1;
        if ({pa_x1, pa_y1, pa_inf1} !== m_op1 || {pa_x2, pa_y2, pa_inf2} !== m_op2)
          stab_err <= stab_err + 1;
        if (m_left <= 1) begin
          m_busy  <= 1'b0;
          pa_done <= 1'b1;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (pa_start) begin
        m_op1 <= {pa_x1, pa_y1, pa_inf1};
        m_op2 <= {pa_x2, pa_y2, pa_inf2};
        {pa_x3, pa_y3, pa_inf3} <= padd(pa_x1, pa_y1, pa_inf1, pa_x2, pa_y2, pa_inf2);
        m_left <= $urandom_range(lat_max, 1);
        m_busy <= 1'b1;
        pa_cnt <= pa_cnt + 1;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the negedge of the done cycle; cyc counts cycles after the accepting edge.
  task automatic run_mult(input logic [255:0] kk, input logic [255:0] xx, input logic [255:0] yy,
                          input logic ii, input bit spam, output int cyc);
    @(negedge clk);
    start = 1'b1; k = kk; px = xx; py = yy; pinf = ii;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < BUDGET) begin
      if (spam && $urandom_range(3, 0) == 0) begin
        start = 1'b1;
        k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL run_timeout k=%h done=%b after %0d cycles, required done=1", kk, done, cyc);
      do_reset();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_done got %b%b required 00", busy, done);
    end
    n_tests++;
    if (rinf !== 1'b1 || rx !== '0 || ry !== '0) begin
      n_fail++; $display("FAIL reset_result got rinf=%b rx=%h ry=%h required rinf=1 rx=ry=0", rinf, rx, ry);
    end
    n_tests++;
    if (pa_start !== 1'b0 || {pa_x1, pa_y1, pa_inf1, pa_x2, pa_y2, pa_inf2} !== '0) begin
      n_fail++; $display("FAIL reset_operands got pa_start=%b inf1=%b inf2=%b required all 0", pa_start, pa_inf1, pa_inf2);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || pa_start !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset got busy=%b done=%b pa_start=%b required 0 0 0", busy, done, pa_start);
    end
  endtask

  task automatic test_shortcut();
    int c0, cyc, e;
    logic [255:0] kr;
    c0 = pa_cnt; e = exp_ops('0, 1'b0);
    run_mult('0, GXC, GYC, 1'b0, 1'b0, cyc);
    n_tests++;
    if (rinf !== 1'b1) begin n_fail++; $display("FAIL k0_rinf got %b required 1", rinf); end
    n_tests++;
    if (pa_cnt - c0 != e) begin n_fail++; $display("FAIL k0_ops got %0d required %0d", pa_cnt - c0, e); end
    n_tests++;
    if ((e == 0) ? (cyc != 3) : (cyc <= 3)) begin
      n_fail++; $display("FAIL k0_latency got %0d cycles, required %s", cyc, (e == 0) ? "3" : "more than 3");
    end
    kr = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    c0 = pa_cnt;
    run_mult(kr, GXC, GYC, 1'b1, 1'b0, cyc);
    n_tests++;
    if (rinf !== 1'b1 || cyc != 3) begin
      n_fail++; $display("FAIL pinf_result got rinf=%b cyc=%0d required rinf=1 cyc=3", rinf, cyc);
    end
    n_tests++;
    if (pa_cnt - c0 != 0) begin n_fail++; $display("FAIL pinf_ops got %0d required 0", pa_cnt - c0); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done got %b required 0", busy); end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got done=%b one cycle later, required 0", done); end
  endtask

  task automatic test_known_vectors();
    logic [255:0] ks [3];
    logic [255:0] xs [3];
    logic [255:0] ys [3];
    int c0, cyc, e;
    ks = '{256'd1, 256'd2, 256'd3};
    xs = '{GXC, G2X, G3X};
    ys = '{GYC, G2Y, G3Y};
    lat_max = 3;
    for (int i = 0; i < 3; i++) begin
      c0 = pa_cnt; e = exp_ops(ks[i], 1'b0);
      run_mult(ks[i], GXC, GYC, 1'b0, 1'b0, cyc);
      n_tests++;
      if (rx !== xs[i] || ry !== ys[i] || rinf !== 1'b0) begin
        n_fail++; $display("FAIL kG_point k=%0d got %h,%h,%b required %h,%h,0", i + 1, rx, ry, rinf, xs[i], ys[i]);
      end
      n_tests++;
      if (pa_cnt - c0 != e) begin n_fail++; $display("FAIL kG_ops k=%0d got %0d required %0d", i + 1, pa_cnt - c0, e); end
    end
  endtask

  task automatic test_group_order();
    int c0, cyc, e;
    lat_max = 2;
    c0 = pa_cnt; e = exp_ops(FN - 256'd1, 1'b0);
    run_mult(FN - 256'd1, GXC, GYC, 1'b0, 1'b0, cyc);
    n_tests++;
    if (rx !== GXC || ry !== FP - GYC || rinf !== 1'b0) begin
      n_fail++; $display("FAIL nm1_point got %h,%h,%b required %h,%h,0", rx, ry, rinf, GXC, FP - GYC);
    end
    n_tests++;
    if (pa_cnt - c0 != e) begin n_fail++; $display("FAIL nm1_ops got %0d required %0d", pa_cnt - c0, e); end
    c0 = pa_cnt; e = exp_ops(FN, 1'b0);
    run_mult(FN, GXC, GYC, 1'b0, 1'b0, cyc);
    n_tests++;
    if (rinf !== 1'b1) begin n_fail++; $display("FAIL n_rinf got %b required 1", rinf); end
    n_tests++;
    if (pa_cnt - c0 != e) begin n_fail++; $display("FAIL n_ops got %0d required %0d", pa_cnt - c0, e); end
  endtask

  task automatic test_random();
    logic [255:0] kr;
    logic [512:0] exp_pt;
    int c0, cyc, e;
    lat_max = 20;
    for (int i = 0; i < 2; i++) begin
      kr = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      exp_pt = ref_mult(kr, G2X, G2Y, 1'b0);
      c0 = pa_cnt; e = exp_ops(kr, 1'b0);
      run_mult(kr, G2X, G2Y, 1'b0, 1'b0, cyc);
      n_tests++;
      if ({rx, ry, rinf} !== exp_pt) begin
        n_fail++; $display("FAIL rand_point k=%h got %h,%h,%b required %h,%h,%b", kr, rx, ry, rinf,
                           exp_pt[512:257], exp_pt[256:1], exp_pt[0]);
      end
      n_tests++;
      if (pa_cnt - c0 != e) begin n_fail++; $display("FAIL rand_ops got %0d required %0d", pa_cnt - c0, e); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    lat_max = 4;
    run_mult(256'd2, GXC, GYC, 1'b0, 1'b1, cyc);
    n_tests++;
    if (rx !== G2X || ry !== G2Y || rinf !== 1'b0) begin
      n_fail++; $display("FAIL start_while_busy got %h,%h,%b required %h,%h,0", rx, ry, rinf, G2X, G2Y);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (rx !== G2X || ry !== G2Y || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL result_hold got rx=%h done=%b busy=%b required rx=%h done=0 busy=0", rx, done, busy, G2X);
    end
    run_mult(256'd3, GXC, GYC, 1'b0, 1'b0, cyc);
    n_tests++;
    if (rx !== G3X || ry !== G3Y) begin
      n_fail++; $display("FAIL second_run got %h,%h required %h,%h", rx, ry, G3X, G3Y);
    end
  endtask

  task automatic test_reset_mid();
    int n, c0, cyc;
    lat_max = 20;
    @(negedge clk);
    start = 1'b1; k = 256'd3; px = GXC; py = GYC; pinf = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (pa_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (pa_start !== 1'b1) begin n_fail++; $display("FAIL mid_first_req got pa_start=%b required 1", pa_start); end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || pa_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_in_wait got busy=%b pa_done=%b required 1 0", busy, pa_done);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || rinf !== 1'b1 || pa_start !== 1'b0 || rx !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs got busy=%b done=%b rinf=%b pa_start=%b required 0 0 1 0", busy, done, rinf, pa_start);
    end
    n_tests++;
    if ({pa_x1, pa_y1, pa_inf1, pa_x2, pa_y2, pa_inf2} !== '0) begin
      n_fail++; $display("FAIL mid_reset_operands got x1=%h inf1=%b required 0", pa_x1, pa_inf1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    c0 = pa_cnt;
    run_mult(256'd2, GXC, GYC, 1'b0, 1'b0, cyc);
    n_tests++;
    if (rx !== G2X || ry !== G2Y || rinf !== 1'b0) begin
      n_fail++; $display("FAIL after_reset_point got %h,%h,%b required %h,%h,0", rx, ry, rinf, G2X, G2Y);
    end
    n_tests++;
    if (pa_cnt - c0 != exp_ops(256'd2, 1'b0)) begin
      n_fail++; $display("FAIL after_reset_ops got %0d required %0d", pa_cnt - c0, exp_ops(256'd2, 1'b0));
    end
  endtask

  task automatic test_handshake();
    n_tests++;
    if (overlap_err != 0) begin n_fail++; $display("FAIL pa_start_overlap got %0d required 0", overlap_err); end
    n_tests++;
    if (stab_err != 0) begin n_fail++; $display("FAIL operand_stability got %0d unstable cycles required 0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_shortcut();
    test_known_vectors();
    test_group_order();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_handshake();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
